sdram_wb_arbiter: RTL and testbench
===================================

# sdram_wb_arbiter

Two-master Wishbone arbiter that shares the single SDRAM controller slave port between the USB loader (master 0, bulk writes of received FX2LP data) and the ConvNet compute engine (master 1, weight/feature reads and result writes). It grants the bus round-robin per bus cycle (`cyc`). It tracks outstanding pipelined requests and aborts a stuck transfer with `err` after a timeout. It sits between both masters and the SDRAM controller's Wishbone slave interface.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles without `s_ack_i` while requests are outstanding before abort.
- `OUTST_MAX`, default 15: maximum outstanding accepted requests; counter width is 4 bits.

Ports:
- `CLKOUT` in 1: single clock. Everything is clocked on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i` in 1 each (N=0,1): master Wishbone controls.
- `mN_sel_i` in 4: master byte selects.
- `mN_addr_i`, `mN_data_i` in 32 each: master address and write data.
- `mN_data_o` out 32: read data, equal to `s_data_i` for both masters.
- `mN_ack_o`, `mN_stall_o`, `mN_err_o` out 1 each: response signals to master N.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: slave-side controls.
- `s_sel_o` out 4, `s_addr_o` out 32, `s_data_o` out 32: slave-side select, address, write data.
- `s_data_i` in 32, `s_ack_i` in 1, `s_stall_i` in 1: SDRAM controller responses.
- `grant` out 2: one-hot current owner; `00` when idle.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`.
- `IDLE`:
  - Only `m0_cyc_i` high → `GNT0`. Only `m1_cyc_i` high → `GNT1`.
  - Both high → grant the master that is not `last`, then set `last` to the granted master.
  - `last` resets to 1, so master 0 wins the first tie.
- `GNTn`:
  - Slave outputs are combinationally muxed from master n.
  - `s_cyc_o` = `mn_cyc_i`; `s_stb_o` = `mn_stb_i` & ~`full`.
  - `mn_stall_o` = `s_stall_i` | `full`; `mn_ack_o` = `s_ack_i`.
- Non-granted master, and both masters in `IDLE`: `stall_o`=1, `ack_o`=0, `err_o`=0.
- Outstanding counter `outst`:
  - +1 on accept (`s_stb_o` & ~`s_stall_i`); −1 on `s_ack_i`; both in the same cycle → unchanged.
  - `full` = (`outst` == `OUTST_MAX`).
  - `s_ack_i` with `outst`==0 is ignored and not forwarded; the counter never underflows.
- Release: granted `cyc` low at a clock edge → `IDLE`.
  - If `outst`≠0 at that edge, the remaining acks are dropped and `outst` clears. Masters must not drop `cyc` early.
- Timeout counter:
  - Clears when `outst`==0 or on `s_ack_i`; otherwise increments.
  - On reaching `TIMEOUT`: `mn_err_o`=1 for one cycle, `outst` clears, FSM → `IDLE`, `s_cyc_o` low the following cycle.
- `IDLE` drives `s_cyc_o`=`s_stb_o`=`s_we_o`=0, `s_sel_o`=0, `s_addr_o`=0, `s_data_o`=0.
- `rst` mid-transfer: return to `IDLE` on the next edge and clear `outst`, timer and `last`. In-flight SDRAM acks are then ignored.

## Timing
- Reset values: all `s_*` outputs 0, `grant`=00, all `ack_o`/`err_o`=0, both `stall_o`=1.
- Grant latency: `cyc` sampled high at edge E → `grant` and `s_cyc_o` valid at E (registered state, combinational mux).
- Re-arbitration: one idle cycle between owners. Master 1 can start no earlier than 2 cycles after master 0 drops `cyc`.
- Ack and read data: zero added latency; combinational pass-through.
- Request throughput: one accept per cycle while the slave does not stall and `outst`<15.

## Structure
- Package `sdram_arb_pkg`:
  - state enum (`IDLE`/`GNT0`/`GNT1`)
  - `OUTST_W`=4
  - default `TIMEOUT` constant
  - master index constants
- Sub-module `rr_arb2`: two request inputs, `last` register, one-hot grant output.
- Mux, counters and FSM live in the top module.

## Test plan
- Reset with both `cyc` high → `grant`=01 one cycle after `rst` falls; `m1_stall_o`=1.
- Master 0 does 4 pipelined writes (addr 0..3, data 0xA0..0xA3), slave acks 2 cycles later → `s_addr_o` shows 0..3, four `m0_ack_o`, `outst` returns to 0.
- Both masters hold `cyc` continuously, each releasing after 1 transfer → grants alternate 01,10,01,10 with one `IDLE` cycle between each.
- Slave never stalls and never acks; master issues 20 strobes → exactly 15 accepted, `m0_stall_o`=1 from the 16th on.
- With `TIMEOUT`=8 and no ack after 1 accept → `m0_err_o` pulses exactly 9 cycles after accept, then `grant`=00.
- Stray `s_ack_i` in `IDLE` → no `ack_o` on either master, `outst` stays 0.

Source files
------------

// File: rtl/sdram_wb_arbiter_pkg.sv
// Shared types and constants for the SDRAM Wishbone arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned OUTST_W       = 4;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned OUTST_MAX_DEF = 15;

  // Master indices: USB loader and ConvNet engine
  localparam int unsigned M_USB = 0;
  localparam int unsigned M_CNN = 1;

endpackage

// File: rtl/sdram_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the SDRAM slave.
// 'slave' is the arbiter's view; 'master' is the view of the masters plus SDRAM controller.
interface sdram_wb_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_stall_o, m0_err_o;

  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_stall_o, m1_err_o;

  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i, s_stall_i;

  logic [1:0]  grant;

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
    output s_data_i, s_ack_i, s_stall_i,
    input  m0_data_o, m0_ack_o, m0_stall_o, m0_err_o,
    input  m1_data_o, m1_ack_o, m1_stall_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o, grant
  );

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i,
    input  s_data_i, s_ack_i, s_stall_i,
    output m0_data_o, m0_ack_o, m0_stall_o, m0_err_o,
    output m1_data_o, m1_ack_o, m1_stall_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o, grant
  );
endinterface

// File: rtl/sdram_wb_arbiter_rr_arb2.sv
// Two-way round-robin chooser: one-hot grant, ties go to the master not served last.
module rr_arb2
  import sdram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_last;

  always_comb begin
    o_gnt = '0;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_last <= 1'(M_CNN);
    else if (i_en && (o_gnt != '0))
      r_last <= o_gnt[M_CNN];
  end

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller: per-cycle round-robin
// ownership, outstanding-request tracking and stuck-transfer abort.
module sdram_wb_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned OUTST_MAX = OUTST_MAX_DEF
) (
  input  logic CLKOUT,
  input  logic rst,
  sdram_wb_arbiter_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  arb_state_t         r_state;
  logic [OUTST_W-1:0] r_outst;
  logic [TMR_W-1:0]   r_timer;

  logic [1:0] w_gnt;
  logic       w_g0, w_g1, w_cyc, w_full, w_accept, w_ack_ok, w_timeout;

  rr_arb2 u_rr (
    .i_clk (CLKOUT),
    .i_rst (rst),
    .i_req ({bus.m1_cyc_i, bus.m0_cyc_i}),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_g0      = (r_state == GNT0);
    w_g1      = (r_state == GNT1);
    w_full    = (r_outst == OUTST_W'(OUTST_MAX));
    w_timeout = (r_timer == TMR_W'(TIMEOUT));

    bus.s_cyc_o    = 1'b0;
    bus.s_stb_o    = 1'b0;
    bus.s_we_o     = 1'b0;
    bus.s_sel_o    = '0;
    bus.s_addr_o   = '0;
    bus.s_data_o   = '0;
    bus.m0_stall_o = 1'b1;
    bus.m1_stall_o = 1'b1;
    bus.m0_ack_o   = 1'b0;
    bus.m1_ack_o   = 1'b0;
    bus.m0_err_o   = 1'b0;
    bus.m1_err_o   = 1'b0;

    if (w_g0) begin
      bus.s_cyc_o    = bus.m0_cyc_i;
      bus.s_stb_o    = bus.m0_stb_i & ~w_full;
      bus.s_we_o     = bus.m0_we_i;
      bus.s_sel_o    = bus.m0_sel_i;
      bus.s_addr_o   = bus.m0_addr_i;
      bus.s_data_o   = bus.m0_data_i;
      bus.m0_stall_o = bus.s_stall_i | w_full;
      bus.m0_ack_o   = bus.s_ack_i & (r_outst != '0);
      bus.m0_err_o   = w_timeout;
    end else if (w_g1) begin
      bus.s_cyc_o    = bus.m1_cyc_i;
      bus.s_stb_o    = bus.m1_stb_i & ~w_full;
      bus.s_we_o     = bus.m1_we_i;
      bus.s_sel_o    = bus.m1_sel_i;
      bus.s_addr_o   = bus.m1_addr_i;
      bus.s_data_o   = bus.m1_data_i;
      bus.m1_stall_o = bus.s_stall_i | w_full;
      bus.m1_ack_o   = bus.s_ack_i & (r_outst != '0);
      bus.m1_err_o   = w_timeout;
    end

    w_cyc    = bus.s_cyc_o;
    w_accept = bus.s_stb_o & ~bus.s_stall_i;
    // Acks with nothing outstanding are strays and never reach the counter
    w_ack_ok = (w_g0 | w_g1) & bus.s_ack_i & (r_outst != '0);

    bus.grant     = {w_g1, w_g0};
    bus.m0_data_o = bus.s_data_i;
    bus.m1_data_o = bus.s_data_i;
  end

  always_ff @(posedge CLKOUT) begin
    if (rst) begin
      r_state <= IDLE;
      r_outst <= '0;
      r_timer <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_outst <= '0;
          r_timer <= '0;
          if (w_gnt[M_USB])
            r_state <= GNT0;
          else if (w_gnt[M_CNN])
            r_state <= GNT1;
        end
        default: begin
          // Release or abort both drop whatever acks are still in flight
          if (!w_cyc || w_timeout) begin
            r_state <= IDLE;
            r_outst <= '0;
            r_timer <= '0;
          end else begin
            r_outst <= r_outst + OUTST_W'(w_accept) - OUTST_W'(w_ack_ok);
            if ((r_outst == '0) || bus.s_ack_i)
              r_timer <= '0;
            else
              r_timer <= r_timer + TMR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Scoreboard bench for sdram_wb_arbiter: stimulus queues expected slave requests, acks
// and grant changes; a negedge monitor pops and compares them as the DUT presents them.
module tb_sdram_wb_arbiter;
  import sdram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_wb_arbiter_if bus ();
  sdram_wb_arbiter_if bus_t ();

  sdram_wb_arbiter dut (
    .CLKOUT (clk),
    .rst    (rst),
    .bus    (bus)
  );

  sdram_wb_arbiter #(.TIMEOUT(8), .OUTST_MAX(15)) dut_t (
    .CLKOUT (clk),
    .rst    (rst),
    .bus    (bus_t)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [68:0] q_req[$];
  logic [31:0] q_ack0[$];
  logic [31:0] q_ack1[$];
  logic [1:0]  q_gnt[$];
  bit          slv_auto = 1'b0;
  bit          chk_idle = 1'b0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {16'hDA7A, a[15:0]};
  endfunction

  // SDRAM model: acks each accepted request two cycles later with address-derived data
  initial begin
    logic        acc;
    logic [31:0] a;
    logic [1:0]  ack_pipe;
    logic [31:0] d0, d1;
    ack_pipe = '0;
    d0 = '0;
    d1 = '0;
    forever begin
      @(negedge clk);
      acc = bus.s_cyc_o & bus.s_stb_o & ~bus.s_stall_i;
      a   = bus.s_addr_o;
      @(posedge clk);
      #1;
      if (slv_auto) begin
        ack_pipe      = {ack_pipe[0], acc};
        d1            = d0;
        d0            = rd_of(a);
        bus.s_ack_i   = ack_pipe[1];
        bus.s_data_i  = d1;
      end else begin
        ack_pipe = '0;
      end
    end
  end

  // Monitor
  initial begin
    logic [1:0] prev_g;
    int         idle_cnt;
    prev_g   = '0;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.s_cyc_o && bus.s_stb_o && !bus.s_stall_i) begin
          if (q_req.size() == 0) fail_now("unexpected_accept");
          else check("slave_req", {bus.s_we_o, bus.s_sel_o, bus.s_addr_o, bus.s_data_o}, q_req.pop_front());
        end
        if (bus.m0_ack_o) begin
          if (q_ack0.size() == 0) fail_now("unexpected_m0_ack");
          else check("m0_ack_data", bus.m0_data_o, q_ack0.pop_front());
        end
        if (bus.m1_ack_o) begin
          if (q_ack1.size() == 0) fail_now("unexpected_m1_ack");
          else check("m1_ack_data", bus.m1_data_o, q_ack1.pop_front());
        end
        if (bus.m0_err_o || bus.m1_err_o) fail_now("unexpected_err");
        if (bus.grant != prev_g) begin
          if (q_gnt.size() == 0) fail_now("unexpected_grant_change");
          else check("grant_seq", bus.grant, q_gnt.pop_front());
          if (chk_idle && prev_g == 2'b00) check("idle_gap", idle_cnt, 1);
          idle_cnt = (bus.grant == 2'b00) ? 1 : 0;
          prev_g   = bus.grant;
        end else if (bus.grant == 2'b00) begin
          idle_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic stb, input logic we, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_stb_i = stb; bus.m0_we_i = we; bus.m0_sel_i = sel;
      bus.m0_addr_i = a;  bus.m0_data_i = d;
    end else begin
      bus.m1_stb_i = stb; bus.m1_we_i = we; bus.m1_sel_i = sel;
      bus.m1_addr_i = a;  bus.m1_data_i = d;
    end
  endtask

  task automatic m_req(input int m, input logic we, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] d);
    bit st;
    set_m(m, 1'b1, we, sel, a, d);
    st = 1'b1;
    for (int i = 0; i < 50 && st; i++) begin
      @(negedge clk);
      st = (m == 0) ? bus.m0_stall_o : bus.m1_stall_o;
      tick();
    end
    if (st) fail_now("req_accept_timeout");
    set_m(m, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic wait_gnt(input bit tbus, input logic [1:0] g);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = ((tbus ? bus_t.grant : bus.grant) == g);
    end
    if (!got) fail_now("grant_wait_timeout");
  endtask

  task automatic wait_ack(input int m, input int remain);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = ((m == 0) ? q_ack0.size() : q_ack1.size()) == remain;
    end
    if (!done) fail_now("ack_wait_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    bus.s_data_i = '0; bus.s_ack_i = 1'b1; bus.s_stall_i = 1'b0;
    bus_t.m0_cyc_i = 1'b0; bus_t.m0_stb_i = 1'b0; bus_t.m0_we_i = 1'b0;
    bus_t.m0_sel_i = '0;   bus_t.m0_addr_i = '0;  bus_t.m0_data_i = '0;
    bus_t.m1_cyc_i = 1'b0; bus_t.m1_stb_i = 1'b0; bus_t.m1_we_i = 1'b0;
    bus_t.m1_sel_i = '0;   bus_t.m1_addr_i = '0;  bus_t.m1_data_i = '0;
    bus_t.s_data_i = 32'h1234_5678; bus_t.s_ack_i = 1'b0; bus_t.s_stall_i = 1'b0;

    // Reset with both masters requesting and a stray ack present
    repeat (3) tick();
    @(negedge clk);
    check("rst_grant", bus.grant, 2'b00);
    check("rst_slave_outs", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_sel_o, bus.s_addr_o, bus.s_data_o}, '0);
    check("rst_stall", {bus.m0_stall_o, bus.m1_stall_o}, 2'b11);
    check("rst_ack_err", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 4'b0000);
    bus.s_ack_i = 1'b0;
    q_gnt.push_back(2'b01);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("grant_before_edge", bus.grant, 2'b00);
    @(negedge clk);
    check("first_tie_grant", bus.grant, 2'b01);
    check("loser_stall", bus.m1_stall_o, 1'b1);
    check("owner_stall", bus.m0_stall_o, 1'b0);
    check("owner_s_cyc", bus.s_cyc_o, 1'b1);
    tick();
    bus.m1_cyc_i = 1'b0;

    // Master 0: four pipelined writes
    slv_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_req.push_back({1'b1, 4'hF, 32'(i), 32'hA0 + 32'(i)});
      q_ack0.push_back(rd_of(32'(i)));
    end
    for (int i = 0; i < 4; i++) m_req(0, 1'b1, 4'hF, 32'(i), 32'hA0 + 32'(i));
    wait_ack(0, 0);
    tick();
    check("outst_drained", dut.r_outst, 0);
    q_gnt.push_back(2'b00);
    bus.m0_cyc_i = 1'b0;
    repeat (2) tick();

    // Fresh reset, then both masters contend, one transfer per tenure
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    q_gnt.push_back(2'b01); q_gnt.push_back(2'b00); q_gnt.push_back(2'b10); q_gnt.push_back(2'b00);
    q_gnt.push_back(2'b01); q_gnt.push_back(2'b00); q_gnt.push_back(2'b10); q_gnt.push_back(2'b00);
    for (int k = 0; k < 2; k++) begin
      q_req.push_back({1'b1, 4'hF, 32'h10 + 32'(k), 32'hB0 + 32'(k)});
      q_req.push_back({1'b0, 4'hC, 32'h100 + 32'(k), 32'h0});
      q_ack0.push_back(rd_of(32'h10 + 32'(k)));
      q_ack1.push_back(rd_of(32'h100 + 32'(k)));
    end
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          bus.m0_cyc_i = 1'b1;
          wait_gnt(1'b0, 2'b01);
          m_req(0, 1'b1, 4'hF, 32'h10 + 32'(k), 32'hB0 + 32'(k));
          chk_idle = 1'b1;
          wait_ack(0, 1 - k);
          bus.m0_cyc_i = 1'b0;
          tick();
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bus.m1_cyc_i = 1'b1;
          wait_gnt(1'b0, 2'b10);
          m_req(1, 1'b0, 4'hC, 32'h100 + 32'(k), 32'h0);
          wait_ack(1, 1 - k);
          bus.m1_cyc_i = 1'b0;
          tick();
        end
      end
    join
    chk_idle = 1'b0;
    repeat (2) tick();

    // Slave never acks: outstanding limit caps accepts at 15
    slv_auto = 1'b0;
    bus.s_ack_i = 1'b0;
    q_gnt.push_back(2'b01);
    bus.m0_cyc_i = 1'b1;
    wait_gnt(1'b0, 2'b01);
    for (int i = 0; i < 15; i++) q_req.push_back({1'b1, 4'hF, 32'h200 + 32'(i), 32'h300 + 32'(i)});
    for (int i = 0; i < 20; i++) begin
      set_m(0, 1'b1, 1'b1, 4'hF, 32'h200 + 32'(i), 32'h300 + 32'(i));
      @(negedge clk);
      check($sformatf("full_stall_%0d", i), bus.m0_stall_o, (i >= 15));
      tick();
    end
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("outst_full", dut.r_outst, 15);
    q_gnt.push_back(2'b00);
    bus.m0_cyc_i = 1'b0;
    repeat (2) tick();
    check("outst_cleared_on_release", dut.r_outst, 0);

    // Stray acks in IDLE, then while owned with nothing outstanding
    bus.s_data_i = 32'hC0FF_EE00;
    bus.s_ack_i  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_idle_acks", {bus.m0_ack_o, bus.m1_ack_o}, 2'b00);
      check("stray_idle_outst", dut.r_outst, 0);
      tick();
    end
    check("rdata_passthru", {bus.m0_data_o, bus.m1_data_o}, {32'hC0FF_EE00, 32'hC0FF_EE00});
    bus.s_ack_i = 1'b0;
    q_gnt.push_back(2'b01);
    bus.m0_cyc_i = 1'b1;
    wait_gnt(1'b0, 2'b01);
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    check("stray_owned_ack", bus.m0_ack_o, 1'b0);
    tick();
    bus.s_ack_i = 1'b0;
    check("stray_owned_outst", dut.r_outst, 0);
    q_gnt.push_back(2'b00);
    bus.m0_cyc_i = 1'b0;
    repeat (2) tick();

    // Timeout abort on the TIMEOUT=8 instance after a single accept
    bus_t.m0_cyc_i = 1'b1;
    wait_gnt(1'b1, 2'b01);
    bus_t.m0_stb_i = 1'b1; bus_t.m0_we_i = 1'b1; bus_t.m0_sel_i = 4'hF;
    bus_t.m0_addr_i = 32'h40; bus_t.m0_data_i = 32'h55;
    @(negedge clk);
    check("t_accept_stall", bus_t.m0_stall_o, 1'b0);
    tick();
    bus_t.m0_stb_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("t_err_c%0d", c), bus_t.m0_err_o, (c == 8));
      check($sformatf("t_grant_c%0d", c), bus_t.grant, (c <= 8) ? 2'b01 : 2'b00);
      if (c == 0) begin
        check("t_loser_outs", {bus_t.m1_stall_o, bus_t.m1_ack_o, bus_t.m1_err_o}, 3'b100);
        check("t_rdata", {bus_t.m0_data_o, bus_t.m1_data_o}, {32'h1234_5678, 32'h1234_5678});
      end
      if (c >= 9)
        check($sformatf("t_idle_outs_c%0d", c),
              {bus_t.s_cyc_o, bus_t.s_stb_o, bus_t.s_we_o, bus_t.s_sel_o, bus_t.s_addr_o, bus_t.s_data_o}, '0);
      if (c == 9) bus_t.m0_cyc_i = 1'b0;
    end

    check("left_req", q_req.size(), 0);
    check("left_ack0", q_ack0.size(), 0);
    check("left_ack1", q_ack1.size(), 0);
    check("left_grant", q_gnt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
